calc_cmd_sequencer: RTL and testbench
=====================================

# calc_cmd_sequencer

Multi-requester command sequencer in front of the binary calculator top. It arbitrates round-robin among `NumReq` requesters, latches the winning operation, and plays the calculator's key-unlock/ValidCmd protocol. It then tracks `Busy` to completion and returns a per-requester done/error pulse. It owns the calculator's command inputs; `DataOut`/`ClkTx` are consumed elsewhere.

## Interface
- `Bits`, 8: operand width (`lnA`/`lnB`).
- `AddrBits`, 32: memory address width.
- `NumReq`, 4: requester count (2..8).
- `TimeoutCycles`, 1023: max cycles waiting on `Busy` per phase.

- `Clk`  in  1  single clock, rising edge.
- `Reset`  in  1  synchronous, active-low reset.
- `Req`  in  NumReq  request level per requester; held until `Done`.
- `ReqA`, `ReqB`  in  NumReq*Bits  packed operands, slot i at [i*Bits +: Bits].
- `ReqSel`  in  NumReq*4  packed ALU select.
- `ReqAddr`  in  NumReq*AddrBits  packed memory address.
- `ReqRW`  in  NumReq  1 = write memory, 0 = read.
- `Gnt`  out  NumReq  one-hot, one-cycle pulse when request accepted.
- `Done`  out  NumReq  one-hot, one-cycle completion pulse.
- `Err`  out  1  high with `Done` when completion was by timeout.
- `InputKey`, `ValidCmd`, `RWMem`  out  1  calculator controls.
- `Addr`  out  AddrBits; `lnA`, `lnB`  out  Bits; `Sel`  out  4: calculator operands.
- `Busy`  in  1  calculator busy.
- `CalcActive`  in  1  calculator unlocked/active.

## Operation
- Reset values: all outputs 0 (`RWMem`=0, `Gnt`/`Done`/`Err`=0). The round-robin pointer resets to 0.
- FSM states: IDLE, KEY, WAIT_BUSY, WAIT_IDLE, RELEASE.
- IDLE, with any `Req` high:
  - Pick the first requester at or after the pointer (wrapping) and latch its A/B/Sel/Addr/RW into the output registers.
  - Pulse `Gnt[i]`, set the pointer to i+1 mod NumReq, and go to KEY.
- KEY: 4 cycles with `ValidCmd`=1 and `InputKey` = 1,0,1,0. Then go to WAIT_BUSY.
- WAIT_BUSY:
  - `Busy`=1 → WAIT_IDLE.
  - `CalcActive`=1 and `Busy`=0 after at least 2 cycles in state (zero-length op) → RELEASE.
  - Timeout → RELEASE with error flag set.
- WAIT_IDLE: `Busy`=0 → RELEASE. Timeout → RELEASE with error flag set.
- RELEASE:
  - One cycle with `ValidCmd`=0 and `InputKey`=0.
  - Pulse `Done[i]`, with `Err` = error flag. Clear the flag and return to IDLE.
- Operand outputs (`lnA`, `lnB`, `Sel`, `Addr`, `RWMem`) hold the latched values from the grant until the next grant. They never change mid-command.
- A requester dropping `Req` after `Gnt` has no effect: the command completes and `Done` still pulses.
- Timeout counter: `$clog2(TimeoutCycles+1)` bits, saturating. It clears on every state entry.

## Timing
- All outputs are registered.
- Request to `Gnt`: `Req` sampled high at edge k → `Gnt` high during cycle k..k+1, with first `InputKey`=1 in the same cycle.
- Back-to-back: the next `Gnt` comes no earlier than 1 cycle after the `Done` pulse (the IDLE sample cycle).
- Minimum command length, `Gnt` to `Done`: 4 (KEY) + 2 + 1 = 7 cycles.
- Simultaneous requests: exactly one `Gnt` per arbitration. Requests are served in rotating order, with no starvation: worst-case wait is NumReq−1 commands.
- `Reset` low at any edge: return to IDLE next cycle with all outputs 0. An in-flight command is dropped with no `Done`, and the pointer resets.
- `Busy` glitch (1→0→1) inside WAIT_IDLE: the first 0 completes the command.

## Structure
- Package `calc_pkg`:
  - State enum `seq_state_e`.
  - `SEL_W`=4, `KEY_SEQ_LEN`=4, and the key pattern constant `KEY_PATTERN`=4'b0101 (LSB first).
- Sub-module `rr_arbiter`:
  - Parameter `N`; ports `req`, `ptr`, output `gnt_onehot` and `gnt_idx`.
  - Purely combinational pick. The pointer register lives in the sequencer.

## Test plan
- Single requester 0, A=8'hAB, B=8'hCD, Sel=0, RW=1, Addr=2. Model raises `Busy` 3 cycles after the KEY phase and holds it 10 cycles → `Gnt[0]`, `InputKey` 1,0,1,0 with `ValidCmd`=1, `lnA`/`lnB` stable AB/CD, then `Done[0]` with `Err`=0, 1 cycle after `Busy` falls.
- Requesters 0, 1 and 3 all high from reset release → `Gnt` order 0, 1, 3, 0 (while requests are held). Each `Done` precedes the next `Gnt`.
- Busy never rises, TimeoutCycles=15 → `Done` with `Err`=1 exactly 4+15+1 cycles after `Gnt`, and `ValidCmd` drops.
- `Reset` low during WAIT_IDLE → next cycle all outputs 0 and no `Done`. After release, a pending `Req[2]` gets `Gnt[2]` from pointer 0 (after scanning 0 and 1).
- `Req[1]` dropped one cycle after `Gnt[1]` → the command still completes and `Done[1]` pulses; `Req[2]` is then served next.
- Zero-length op: `CalcActive`=1 and `Busy` stays 0 → `Done` 7 cycles after `Gnt`, `Err`=0.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared state type and key-unlock constants for the calculator command sequencer
package calc_pkg;
  typedef enum logic [2:0] {IDLE, KEY, WAIT_BUSY, WAIT_IDLE, RELEASE} seq_state_e;
  localparam int SEL_W = 4;
  localparam int KEY_SEQ_LEN = 4;
  localparam logic [KEY_SEQ_LEN-1:0] KEY_PATTERN = 4'b0101;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr, wrapping
// req: request levels; ptr: search start; gnt_onehot/gnt_idx: winner (all zero when no request)
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt_onehot,
  output logic [$clog2(N)-1:0] gnt_idx
);
  localparam int W = $clog2(N);
  logic [W:0]   s;
  logic [W-1:0] idx;
  // scan offsets from farthest to nearest so the nearest hit is the last write
  always_comb begin
    gnt_onehot = '0;
    gnt_idx = '0;
    s = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      s = {1'b0, ptr} + (W+1)'(k);
      idx = s >= (W+1)'(N) ? W'(s - (W+1)'(N)) : s[W-1:0];
      if (req[idx]) begin
        gnt_onehot = '0;
        gnt_onehot[idx] = 1'b1;
        gnt_idx = idx;
      end
    end
  end
endmodule

// File: rtl/calc_cmd_sequencer.sv
// calc_cmd_sequencer: round-robin command sequencer driving the calculator key/ValidCmd protocol
// Clk/Reset: clock, sync active-low reset; Req*/Gnt/Done/Err: requester side
// InputKey/ValidCmd/RWMem/Addr/lnA/lnB/Sel: calculator command outputs; Busy/CalcActive: calculator status
module calc_cmd_sequencer
  import calc_pkg::*;
#(
  parameter int Bits = 8,
  parameter int AddrBits = 32,
  parameter int NumReq = 4,
  parameter int TimeoutCycles = 1023
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic [NumReq-1:0]            Req,
  input  logic [NumReq*Bits-1:0]       ReqA,
  input  logic [NumReq*Bits-1:0]       ReqB,
  input  logic [NumReq*SEL_W-1:0]      ReqSel,
  input  logic [NumReq*AddrBits-1:0]   ReqAddr,
  input  logic [NumReq-1:0]            ReqRW,
  output logic [NumReq-1:0]            Gnt,
  output logic [NumReq-1:0]            Done,
  output logic                         Err,
  output logic                         InputKey,
  output logic                         ValidCmd,
  output logic                         RWMem,
  output logic [AddrBits-1:0]          Addr,
  output logic [Bits-1:0]              lnA,
  output logic [Bits-1:0]              lnB,
  output logic [SEL_W-1:0]             Sel,
  input  logic                         Busy,
  input  logic                         CalcActive
);
  localparam int PW = $clog2(NumReq);
  localparam int TW = $clog2(TimeoutCycles + 1);
  localparam int KW = $clog2(KEY_SEQ_LEN);
  seq_state_e state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, idx_q, idx_d, gnt_idx;
  logic [NumReq-1:0] gnt_oh, gnt_q, gnt_d, done_q, done_d;
  logic [KW-1:0] kcnt_q, kcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic eflag_q, eflag_d, err_q, err_d, key_q, key_d, valid_q, valid_d, rw_q, rw_d;
  logic [AddrBits-1:0] addr_q, addr_d;
  logic [Bits-1:0] a_q, a_d, b_q, b_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic grant, timeout;

  rr_arbiter #(.N(NumReq)) u_arb (
    .req(Req),
    .ptr(ptr_q),
    .gnt_onehot(gnt_oh),
    .gnt_idx(gnt_idx)
  );

  assign grant = state_q == IDLE && |Req;
  assign timeout = tcnt_q >= TW'(TimeoutCycles - 1);

  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    idx_d = idx_q;
    kcnt_d = kcnt_q;
    eflag_d = eflag_q;
    unique case (state_q)
      IDLE: if (grant) begin
        state_d = KEY;
        ptr_d = gnt_idx == PW'(NumReq - 1) ? '0 : gnt_idx + 1'b1;
        idx_d = gnt_idx;
        kcnt_d = '0;
      end
      KEY: begin
        kcnt_d = kcnt_q + 1'b1;
        state_d = kcnt_q == KW'(KEY_SEQ_LEN - 1) ? WAIT_BUSY : KEY;
      end
      // a zero-length op is only trusted from the second cycle so Busy has a chance to rise
      WAIT_BUSY: if (Busy) state_d = WAIT_IDLE;
        else if (CalcActive && tcnt_q != '0) state_d = RELEASE;
        else if (timeout) begin
          state_d = RELEASE;
          eflag_d = 1'b1;
        end
      WAIT_IDLE: if (!Busy) state_d = RELEASE;
        else if (timeout) begin
          state_d = RELEASE;
          eflag_d = 1'b1;
        end
      RELEASE: begin
        state_d = IDLE;
        eflag_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tcnt_d = state_d != state_q ? '0 : &tcnt_q ? tcnt_q : tcnt_q + 1'b1;
    gnt_d = grant ? gnt_oh : '0;
    done_d = state_q == RELEASE ? NumReq'(1) << idx_q : '0;
    err_d = state_q == RELEASE && eflag_q;
    key_d = state_d == KEY && KEY_PATTERN[kcnt_d];
    valid_d = state_d == KEY || state_d == WAIT_BUSY || state_d == WAIT_IDLE;
    a_d = a_q;
    b_d = b_q;
    sel_d = sel_q;
    addr_d = addr_q;
    rw_d = rw_q;
    for (int i = 0; i < NumReq; i++)
      if (grant && gnt_oh[i]) begin
        a_d = ReqA[i*Bits +: Bits];
        b_d = ReqB[i*Bits +: Bits];
        sel_d = ReqSel[i*SEL_W +: SEL_W];
        addr_d = ReqAddr[i*AddrBits +: AddrBits];
        rw_d = ReqRW[i];
      end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      idx_q <= '0;
      kcnt_q <= '0;
      tcnt_q <= '0;
      eflag_q <= 1'b0;
      gnt_q <= '0;
      done_q <= '0;
      err_q <= 1'b0;
      key_q <= 1'b0;
      valid_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      sel_q <= '0;
      addr_q <= '0;
      rw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      kcnt_q <= kcnt_d;
      tcnt_q <= tcnt_d;
      eflag_q <= eflag_d;
      gnt_q <= gnt_d;
      done_q <= done_d;
      err_q <= err_d;
      key_q <= key_d;
      valid_q <= valid_d;
      a_q <= a_d;
      b_q <= b_d;
      sel_q <= sel_d;
      addr_q <= addr_d;
      rw_q <= rw_d;
    end
  end

  assign Gnt = gnt_q;
  assign Done = done_q;
  assign Err = err_q;
  assign InputKey = key_q;
  assign ValidCmd = valid_q;
  assign RWMem = rw_q;
  assign Addr = addr_q;
  assign lnA = a_q;
  assign lnB = b_q;
  assign Sel = sel_q;
endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// tb_calc_cmd_sequencer: scoreboard bench for the calculator command sequencer
module tb_calc_cmd_sequencer;
  typedef struct {
    int idx;
    int lat;
    bit err;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
    logic rw;
    logic [31:0] addr;
    int t0;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset, Busy, CalcActive, Err, InputKey, ValidCmd, RWMem;
  logic [3:0] Req, ReqRW, Gnt, Done, Sel;
  logic [31:0] ReqA, ReqB;
  logic [15:0] ReqSel;
  logic [127:0] ReqAddr;
  logic [31:0] Addr;
  logic [7:0] lnA, lnB;

  exp_t exp_q[$];
  exp_t pend_q[$];
  int checks = 0, errors = 0;
  int cyc = 0, since = 1000, dly = 0, len = 0;
  bit busy_en = 0, auto_drop = 1, prev_valid = 0;
  logic [3:0] keys, vals;

  calc_cmd_sequencer #(.Bits(8), .AddrBits(32), .NumReq(4), .TimeoutCycles(15)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .ReqA(ReqA), .ReqB(ReqB), .ReqSel(ReqSel),
    .ReqAddr(ReqAddr), .ReqRW(ReqRW), .Gnt(Gnt), .Done(Done), .Err(Err),
    .InputKey(InputKey), .ValidCmd(ValidCmd), .RWMem(RWMem), .Addr(Addr),
    .lnA(lnA), .lnB(lnB), .Sel(Sel), .Busy(Busy), .CalcActive(CalcActive)
  );

  initial forever #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog got stuck exp finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] fa(int i); return 8'hAB ^ 8'(i * 17); endfunction
  function automatic logic [7:0] fb(int i); return 8'hCD + 8'(i); endfunction
  function automatic logic [3:0] fs(int i); return 4'(i * 3); endfunction
  function automatic logic fr(int i); return i % 2 == 0; endfunction
  function automatic logic [31:0] fd(int i); return 32'h2 + 32'(i * 256); endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int idx, input int lat, input bit err);
    exp_t e;
    e.idx = idx;
    e.lat = lat;
    e.err = err;
    e.a = fa(idx);
    e.b = fb(idx);
    e.sel = fs(idx);
    e.rw = fr(idx);
    e.addr = fd(idx);
    e.t0 = 0;
    exp_q.push_back(e);
  endtask

  function automatic logic [63:0] outs();
    return {Gnt, Done, Err, InputKey, ValidCmd, RWMem, Sel, lnA, lnB, Addr};
  endfunction

  // one cycle: sample DUT at negedge, score grants/completions, then drive the calculator model
  task automatic tick();
    exp_t e;
    @(negedge Clk);
    cyc++;
    since = since < 1000 ? since + 1 : since;
    if (|Gnt) begin
      since = 0;
      if (exp_q.size() == 0) chk("gnt_unexp", 64'(Gnt), 0);
      else begin
        e = exp_q.pop_front();
        chk("gnt", 64'(Gnt), 64'(1) << e.idx);
        chk("lnA", 64'(lnA), 64'(e.a));
        chk("lnB", 64'(lnB), 64'(e.b));
        chk("sel", 64'(Sel), 64'(e.sel));
        chk("addr", 64'(Addr), 64'(e.addr));
        chk("rw", 64'(RWMem), 64'(e.rw));
        e.t0 = cyc;
        pend_q.push_back(e);
      end
    end
    if (since < 4) begin
      keys = {InputKey, keys[3:1]};
      vals = {ValidCmd, vals[3:1]};
      if (since == 3) begin
        chk("key_seq", 64'(keys), 64'h5);
        chk("key_valid", 64'(vals), 64'hf);
      end
    end
    if (|Done) begin
      if (pend_q.size() == 0) chk("done_unexp", 64'(Done), 0);
      else begin
        e = pend_q.pop_front();
        chk("done", 64'(Done), 64'(1) << e.idx);
        chk("err", 64'(Err), 64'(e.err));
        chk("latency", 64'(cyc - e.t0), 64'(e.lat));
        chk("hold_a", 64'(lnA), 64'(e.a));
        chk("hold_b", 64'(lnB), 64'(e.b));
        chk("release_valid", 64'(prev_valid), 0);
        if (auto_drop) Req[e.idx] = 1'b0;
      end
    end
    prev_valid = ValidCmd;
    Busy = busy_en && since >= 4 + dly && since < 4 + dly + len;
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n && (exp_q.size() != 0 || pend_q.size() != 0); i++) tick();
    chk(tag, 64'(exp_q.size() + pend_q.size()), 0);
  endtask

  initial begin
    Reset = 1'b0;
    Req = '0;
    Busy = 1'b0;
    CalcActive = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ReqA[i*8 +: 8] = fa(i);
      ReqB[i*8 +: 8] = fb(i);
      ReqSel[i*4 +: 4] = fs(i);
      ReqRW[i] = fr(i);
      ReqAddr[i*32 +: 32] = fd(i);
    end
    repeat (3) tick();
    chk("reset_outs", outs(), 0);
    Reset = 1'b1;
    // single command with Busy high for 10 cycles, 3 cycles after the key phase
    busy_en = 1; dly = 3; len = 10; auto_drop = 1;
    push(0, 19, 0);
    Req = 4'b0001;
    run(60, "t1_drain");
    repeat (2) tick();
    // rotation 0,1,3,0 from reset release with requests held
    Reset = 1'b0; busy_en = 0; CalcActive = 1; auto_drop = 0;
    Req = 4'b1011;
    repeat (2) tick();
    push(0, 7, 0); push(1, 7, 0); push(3, 7, 0); push(0, 7, 0);
    Reset = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    Req = '0;
    run(30, "t2_drain");
    repeat (2) tick();
    // Busy never rises: timeout with error
    CalcActive = 0; auto_drop = 1;
    push(1, 20, 1);
    Req = 4'b0010;
    run(60, "t3_drain");
    repeat (2) tick();
    // reset during WAIT_IDLE drops the command and the pointer
    busy_en = 1; dly = 0; len = 12;
    push(2, 0, 0);
    Req = 4'b0100;
    for (int i = 0; i < 60 && !(pend_q.size() == 1 && since == 8); i++) tick();
    chk("t4_reached", 64'(since), 8);
    Reset = 1'b0; busy_en = 0; CalcActive = 1;
    pend_q.delete();
    Req = 4'b1100;
    tick();
    chk("t4_reset_outs", outs(), 0);
    push(2, 7, 0); push(3, 7, 0);
    Reset = 1'b1;
    run(60, "t4_drain");
    repeat (2) tick();
    // requester 1 drops Req one cycle after its grant
    push(1, 7, 0); push(2, 7, 0);
    Req = 4'b0110;
    for (int i = 0; i < 20 && exp_q.size() != 1; i++) tick();
    tick();
    Req[1] = 1'b0;
    run(60, "t5_drain");
    repeat (2) tick();
    // zero-length op on requester 3
    push(3, 7, 0);
    Req = 4'b1000;
    run(30, "t6_drain");
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
